memory_access_initiator: RTL

- Core-side requester for the memory control FSM.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Issues it to the memory control FSM as a single-cycle load/store pulse and holds address/data stable until completion (output_valid or write_ready).
- Returns load data or a store acknowledge, with error status, over a valid/ready response channel.

---
 rtl/memory_access_initiator.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_access_initiator.sv
// ---------------------------------------------------------------------------
// memory_access_initiator
//
// Core-side requester for the memory control FSM. It accepts one load/store
// request at a time from the execute stage. Each request is issued to the
// memory control FSM as a single-cycle load/store pulse. The latched
// address and data stay stable until completion. Load data or a store
// acknowledge is then returned, with error status, over a valid/ready
// response channel.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-low reset
//   req_*             request channel from execute (valid/ready handshake)
//   load, store       single-cycle issue pulses to the memory control FSM
//   word_type,
//   is_signed_fsm,
//   mem_addr,
//   mem_wdata         latched request attributes presented to the FSM
//   busy              FSM cannot accept an issue this cycle
//   output_valid      load data valid (one cycle)
//   write_ready       store complete (one cycle)
//   load_data         assembled load result from the FSM
//   resp_*            response channel back to the core
// ---------------------------------------------------------------------------
module memory_access_initiator #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 15,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_word_type,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              load,
  output logic              store,
  output logic [1:0]        word_type,
  output logic              is_signed_fsm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              busy,
  input  logic              output_valid,
  input  logic              write_ready,
  input  logic [31:0]       load_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                store_q, store_d;
  logic [1:0]          type_q, type_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                done_s;

  // Illegal type, or misaligned halfword/word when alignment checking is on.
  function automatic logic req_bad(input logic [1:0] wt, input logic [1:0] low);
    logic bad;
    case (wt)
      2'b11:   bad = 1'b1;
      2'b10:   bad = CHECK_ALIGN && (low != 2'b00);
      2'b01:   bad = CHECK_ALIGN && low[0];
      2'b00:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Only the completion matching the outstanding kind counts; the other is ignored.
  assign done_s = store_q ? write_ready : output_valid;

  // Next-state and next-value logic for the single outstanding transaction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    type_d   = type_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          store_d  = req_store;
          type_d   = req_word_type;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_bad(req_word_type, req_addr[1:0])) begin
            // Rejected requests answer directly; nothing reaches the FSM.
            rdata_d = 32'd0;
            error_d = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!busy) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion is tested first so it wins over a same-cycle timeout.
        if (done_s) begin
          rdata_d = store_q ? 32'd0 : load_data;
          error_d = 1'b0;
          state_d = S_RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          rdata_d = 32'd0;
          error_d = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // State, latched request and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      store_q      <= 1'b0;
      type_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      error_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      type_q       <= type_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // The issue pulse must react to busy in the same cycle, so it is decoded
  // from the registered state rather than registered itself.
  assign load          = (state_q == S_ISSUE) && !busy && !store_q;
  assign store         = (state_q == S_ISSUE) && !busy && store_q;
  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign word_type     = type_q;
  assign is_signed_fsm = signed_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign resp_rdata    = rdata_q;
  assign resp_error    = error_q;

endmodule
